// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//   SPI initiator for a single-clock SPI slave (SS_n/MOSI/MISO all sampled on
//   the system clock). One command is taken per valid/ready handshake and sent
//   MSB first as an 11-bit frame {op[1], op[1:0], payload[7:0]}. A read-data
//   command (op=11) is followed by RD_WAIT turnaround cycles and 8 MISO bits,
//   and the received byte is returned on the response port.
//
// Parameters
//   RD_WAIT      turnaround cycles between the last frame bit and the first
//                MISO sample (op=11 only)
//   GAP          cycles SS_n stays high after a frame before the next one may
//                start (>= 1, at most 16)
//
// Ports
//   clk_i        system clock, also the SPI bit clock
//   rst_i        asynchronous reset, active high
//   cmd_valid_i  command request
//   cmd_ready_o  command can be accepted this cycle
//   cmd_op_i     00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_data_i   address/data payload (zeros are sent for op=11)
//   rsp_valid_o  one-cycle pulse when rsp_data_o is updated by a read
//   rsp_data_o   last byte read from MISO, held until the next read completes
//   busy_o       high from acceptance until the controller is idle again
//   SS_n_o       slave select, active low
//   MOSI_o       serial data to slave
//   MISO_i       serial data from slave
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned GAP     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       busy_o,
  output logic       SS_n_o,
  output logic       MOSI_o,
  input  logic       MISO_i
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    RECV,
    STOP
  } state_e;

  localparam logic [3:0] LAST_BIT  = 4'd10;
  localparam logic [3:0] LAST_RECV = 4'd7;

  state_e      state_q,     state_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [10:0] frame_q,     frame_d;
  logic        isRead_q,    isRead_d;
  logic [7:0]  rxShift_q,   rxShift_d;
  logic        ssN_q,       ssN_d;
  logic        mosi_q,      mosi_d;
  logic        cmdReady_q,  cmdReady_d;
  logic        busy_q,      busy_d;
  logic        rspValid_q,  rspValid_d;
  logic [7:0]  rspData_q,   rspData_d;

  logic        accept;
  logic        cmdIsRead;

  assign accept    = cmd_valid_i && cmdReady_q;
  assign cmdIsRead = (cmd_op_i == 2'b11);

  // State and output registers. Every output comes straight from a flop, so
  // the next-state logic below also decides what the pins show next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      isRead_q   <= 1'b0;
      rxShift_q  <= '0;
      ssN_q      <= 1'b1;
      mosi_q     <= 1'b0;
      cmdReady_q <= 1'b1;
      busy_q     <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      isRead_q   <= isRead_d;
      rxShift_q  <= rxShift_d;
      ssN_q      <= ssN_d;
      mosi_q     <= mosi_d;
      cmdReady_q <= cmdReady_d;
      busy_q     <= busy_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
    end
  end

  // Next-state and next-output logic. The frame register shifts left so the
  // bit to be driven next is always frame_q[10].
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    isRead_d   = isRead_q;
    rxShift_d  = rxShift_q;
    ssN_d      = ssN_q;
    mosi_d     = 1'b0;
    cmdReady_d = cmdReady_q;
    busy_d     = busy_q;
    rspValid_d = 1'b0;
    rspData_d  = rspData_q;

    case (state_q)
      IDLE: begin
        ssN_d = 1'b1;
      end

      START: begin
        state_d = SHIFT;
        cnt_d   = '0;
        mosi_d  = frame_q[10];
        frame_d = {frame_q[9:0], 1'b0};
      end

      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (isRead_q) begin
            state_d = (RD_WAIT == 0) ? RECV : WAIT;
          end else begin
            state_d    = STOP;
            ssN_d      = 1'b1;
            cmdReady_d = (GAP <= 1);
          end
        end else begin
          cnt_d   = cnt_q + 4'd1;
          mosi_d  = frame_q[10];
          frame_d = {frame_q[9:0], 1'b0};
        end
      end

      WAIT: begin
        if (32'(cnt_q) + 32'd1 >= RD_WAIT) begin
          state_d = RECV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      // MISO is only ever looked at here, so an undriven line outside the
      // receive window cannot leak into the response.
      RECV: begin
        rxShift_d = {rxShift_q[6:0], MISO_i};
        if (cnt_q == LAST_RECV) begin
          state_d    = STOP;
          cnt_d      = '0;
          ssN_d      = 1'b1;
          rspValid_d = 1'b1;
          rspData_d  = {rxShift_q[6:0], MISO_i};
          cmdReady_d = (GAP <= 1);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      // cmd_ready rises for the final STOP cycle, so a waiting command is
      // accepted at its end and SS_n stays high for exactly GAP cycles.
      STOP: begin
        if (32'(cnt_q) + 32'd1 >= GAP) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d      = cnt_q + 4'd1;
          cmdReady_d = (32'(cnt_q) + 32'd2 >= GAP);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance can only happen in IDLE or the final STOP cycle and takes
    // priority over whatever those states would otherwise do.
    if (accept) begin
      state_d    = START;
      cnt_d      = '0;
      isRead_d   = cmdIsRead;
      frame_d    = {cmd_op_i[1], cmd_op_i, cmdIsRead ? 8'h00 : cmd_data_i};
      ssN_d      = 1'b0;
      mosi_d     = 1'b0;
      cmdReady_d = 1'b0;
      busy_d     = 1'b1;
    end
  end

  assign cmd_ready_o = cmdReady_q;
  assign rsp_valid_o = rspValid_q;
  assign rsp_data_o  = rspData_q;
  assign busy_o      = busy_q;
  assign SS_n_o      = ssN_q;
  assign MOSI_o      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
//   Directed bench for spi_master_ctrl. A small behavioural slave (address
//   register plus 256-byte memory) decodes the frames seen on SS_n/MOSI and
//   answers read-data frames on MISO, leaving MISO at X everywhere else.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

  localparam int RD_WAIT = 2;
  localparam int GAP     = 2;

  logic       clk;
  logic       rst;
  logic       cmdValid;
  logic       cmdReady;
  logic [1:0] cmdOp;
  logic [7:0] cmdData;
  logic       rspValid;
  logic [7:0] rspData;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int total = 0;
  int bad   = 0;

  // Behavioural slave state
  int          slvCnt = 0;
  logic [10:0] slvShift = '0;
  logic [7:0]  slvAddr = '0;
  bit          slvRead = 1'b0;
  logic [7:0]  slvMem [256];

  // Response value the DUT should be holding on rsp_data
  logic [7:0]  heldRsp = 8'h00;

  spi_master_ctrl #(
    .RD_WAIT(RD_WAIT),
    .GAP    (GAP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmdValid),
    .cmd_ready_o(cmdReady),
    .cmd_op_i   (cmdOp),
    .cmd_data_i (cmdData),
    .rsp_valid_o(rspValid),
    .rsp_data_o (rspData),
    .busy_o     (busy),
    .SS_n_o     (SS_n),
    .MOSI_o     (MOSI),
    .MISO_i     (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdData  = data;
  endtask

  // Advance to 1 time unit after the next rising edge, then let the slave
  // look at this cycle's SS_n/MOSI and set MISO for the same cycle.
  task automatic stepCycle();
    logic [7:0] rdByte;
    @(posedge clk);
    #1;
    if (SS_n !== 1'b0) begin
      slvCnt  = 0;
      slvRead = 1'b0;
      MISO    = 1'bx;
    end else begin
      slvCnt++;
      if (slvCnt >= 2 && slvCnt <= 12) slvShift = {slvShift[9:0], MOSI};
      if (slvCnt == 12) begin
        case (slvShift[9:8])
          2'b00: slvAddr = slvShift[7:0];
          2'b01: slvMem[slvAddr] = slvShift[7:0];
          2'b10: slvAddr = slvShift[7:0];
          default: slvRead = 1'b1;
        endcase
      end
      if (slvRead && slvCnt >= 13 + RD_WAIT && slvCnt <= 20 + RD_WAIT) begin
        rdByte = slvMem[slvAddr];
        MISO   = rdByte[20 + RD_WAIT - slvCnt];
      end else begin
        MISO = 1'bx;
      end
    end
  endtask

  // Runs one command whose request is already on the inputs. expFrame is the
  // hand-written 11-bit frame expected on MOSI; rdExpect is the byte a read
  // should return. With chain set, cmd_valid stays high and the next command
  // is presented in the last gap cycle.
  task automatic runFrame(input logic [1:0] op, input logic [10:0] expFrame, input logic [7:0] rdExpect,
                          input bit chain, input logic [1:0] nOp, input logic [7:0] nData);
    bit isRd;
    isRd = (op == 2'b11);
    stepCycle();
    if (!chain) cmdValid = 1'b0;
    cmdOp   = ~op;
    cmdData = 8'hA5;
    checkOutput($sformatf("op%0d start ss_n", op), {7'b0, SS_n}, 8'd0);
    checkOutput($sformatf("op%0d start mosi", op), {7'b0, MOSI}, 8'd0);
    checkOutput($sformatf("op%0d start ready", op), {7'b0, cmdReady}, 8'd0);
    checkOutput($sformatf("op%0d start busy", op), {7'b0, busy}, 8'd1);
    for (int k = 10; k >= 0; k--) begin
      stepCycle();
      checkOutput($sformatf("op%0d bit%0d ss_n", op, k), {7'b0, SS_n}, 8'd0);
      checkOutput($sformatf("op%0d bit%0d mosi", op, k), {7'b0, MOSI}, {7'b0, expFrame[k]});
    end
    if (isRd) begin
      for (int i = 0; i < RD_WAIT + 8; i++) begin
        stepCycle();
        checkOutput($sformatf("rd turn/recv%0d ss_n", i), {7'b0, SS_n}, 8'd0);
        checkOutput($sformatf("rd turn/recv%0d mosi", i), {7'b0, MOSI}, 8'd0);
        checkOutput($sformatf("rd turn/recv%0d rsp_valid", i), {7'b0, rspValid}, 8'd0);
      end
      heldRsp = rdExpect;
    end
    for (int g = 1; g <= GAP; g++) begin
      stepCycle();
      checkOutput($sformatf("op%0d gap%0d ss_n", op, g), {7'b0, SS_n}, 8'd1);
      checkOutput($sformatf("op%0d gap%0d mosi", op, g), {7'b0, MOSI}, 8'd0);
      checkOutput($sformatf("op%0d gap%0d rsp_valid", op, g), {7'b0, rspValid}, (g == 1 && isRd) ? 8'd1 : 8'd0);
      checkOutput($sformatf("op%0d gap%0d rsp_data", op, g), rspData, heldRsp);
      checkOutput($sformatf("op%0d gap%0d busy", op, g), {7'b0, busy}, 8'd1);
      // Ready is offered during the last gap cycle only
      checkOutput($sformatf("op%0d gap%0d ready", op, g), {7'b0, cmdReady}, (g == GAP) ? 8'd1 : 8'd0);
      if (g == GAP && chain) applyStimulus(nOp, nData);
    end
    if (!chain) begin
      stepCycle();
      checkOutput($sformatf("op%0d idle ss_n", op), {7'b0, SS_n}, 8'd1);
      checkOutput($sformatf("op%0d idle ready", op), {7'b0, cmdReady}, 8'd1);
      checkOutput($sformatf("op%0d idle busy", op), {7'b0, busy}, 8'd0);
      checkOutput($sformatf("op%0d idle rsp_valid", op), {7'b0, rspValid}, 8'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    cmdValid = 1'b0;
    cmdOp    = 2'b00;
    cmdData  = 8'h00;
    MISO     = 1'bx;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ss_n", {7'b0, SS_n}, 8'd1);
    checkOutput("reset mosi", {7'b0, MOSI}, 8'd0);
    checkOutput("reset ready", {7'b0, cmdReady}, 8'd1);
    checkOutput("reset busy", {7'b0, busy}, 8'd0);
    checkOutput("reset rsp_valid", {7'b0, rspValid}, 8'd0);
    checkOutput("reset rsp_data", rspData, 8'h00);
    rst = 1'b0;
    stepCycle();
    checkOutput("idle ready", {7'b0, cmdReady}, 8'd1);

    // Write address 0x0A, write data 0x55, read address 0x0A, read data
    applyStimulus(2'b00, 8'h0A);
    runFrame(2'b00, 11'b000_0000_1010, 8'h00, 1'b0, 2'b00, 8'h00);
    applyStimulus(2'b01, 8'h55);
    runFrame(2'b01, 11'b001_0101_0101, 8'h00, 1'b0, 2'b00, 8'h00);
    applyStimulus(2'b10, 8'h0A);
    runFrame(2'b10, 11'b110_0000_1010, 8'h00, 1'b0, 2'b00, 8'h00);
    applyStimulus(2'b11, 8'hFF);
    runFrame(2'b11, 11'b111_0000_0000, 8'h55, 1'b0, 2'b00, 8'h00);

    // Back-to-back write address 0x3C then write data 0xC3, then read back
    applyStimulus(2'b00, 8'h3C);
    runFrame(2'b00, 11'b000_0011_1100, 8'h00, 1'b1, 2'b01, 8'hC3);
    runFrame(2'b01, 11'b001_1100_0011, 8'h00, 1'b0, 2'b00, 8'h00);
    applyStimulus(2'b10, 8'h3C);
    runFrame(2'b10, 11'b110_0011_1100, 8'h00, 1'b0, 2'b00, 8'h00);
    applyStimulus(2'b11, 8'h00);
    runFrame(2'b11, 11'b111_0000_0000, 8'hC3, 1'b0, 2'b00, 8'h00);

    // Reset during cycle 7 of a read-data frame
    applyStimulus(2'b11, 8'h00);
    stepCycle();
    cmdValid = 1'b0;
    repeat (6) stepCycle();
    checkOutput("pre-abort ss_n", {7'b0, SS_n}, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    heldRsp = 8'h00;
    checkOutput("abort ss_n", {7'b0, SS_n}, 8'd1);
    checkOutput("abort mosi", {7'b0, MOSI}, 8'd0);
    checkOutput("abort ready", {7'b0, cmdReady}, 8'd1);
    checkOutput("abort busy", {7'b0, busy}, 8'd0);
    checkOutput("abort rsp_data", rspData, 8'h00);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput($sformatf("in reset%0d rsp_valid", i), {7'b0, rspValid}, 8'd0);
      checkOutput($sformatf("in reset%0d ss_n", i), {7'b0, SS_n}, 8'd1);
    end
    #2;
    rst = 1'b0;
    stepCycle();
    checkOutput("post-reset ready", {7'b0, cmdReady}, 8'd1);
    checkOutput("post-reset rsp_valid", {7'b0, rspValid}, 8'd0);

    // Clean write after the aborted frame
    applyStimulus(2'b00, 8'h81);
    runFrame(2'b00, 11'b000_1000_0001, 8'h00, 1'b0, 2'b00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
